// File: rtl/mtrap_csr_bank.sv
// Machine-mode trap CSR bank: mscratch, mepc, mcause and mtval, with CSR read/modify/write,
// trap capture, MRET tracking and a sticky double-trap flag.
module mtrap_csr_bank #(
    parameter int unsigned    XLEN           = 32,
    parameter int unsigned    IALIGN         = 32,
    parameter int unsigned    CAUSE_W        = 5,
    parameter logic [11:0]    MSCRATCH_ADDR  = 12'h340,
    parameter logic [11:0]    MEPC_ADDR      = 12'h341,
    parameter logic [11:0]    MCAUSE_ADDR    = 12'h342,
    parameter logic [11:0]    MTVAL_ADDR     = 12'h343,
    parameter logic [XLEN-1:0] MSCRATCH_RESET = '0,
    parameter logic [XLEN-1:0] MEPC_RESET     = '0
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic [11:0]     csr_addr_in,
    input  logic            wr_en_in,
    input  logic [1:0]      csr_op_in,
    input  logic [XLEN-1:0] data_wr_in,
    input  logic            trap_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] cause_in,
    input  logic [XLEN-1:0] tval_in,
    input  logic            mret_in,
    output logic [XLEN-1:0] rd_data_out,
    output logic            hit_out,
    output logic [XLEN-1:0] mscratch_out,
    output logic [XLEN-1:0] mepc_out,
    output logic [XLEN-1:0] mcause_out,
    output logic [XLEN-1:0] mtval_out,
    output logic [XLEN-1:0] epc_out,
    output logic            in_trap_out,
    output logic            double_trap_out
);

    // IALIGN=16 keeps mepc[1]; any other setting is treated as 32-bit alignment
    localparam int unsigned ALIGN_BITS = (IALIGN == 16) ? 1 : 2;
    localparam logic [XLEN-1:0] EPC_MASK =
        {{(XLEN - ALIGN_BITS){1'b1}}, {ALIGN_BITS{1'b0}}};
    localparam logic [XLEN-1:0] CAUSE_MASK =
        {1'b1, {(XLEN - 1 - CAUSE_W){1'b0}}, {CAUSE_W{1'b1}}};

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mtval_q;
    logic            in_trap_q;
    logic            double_trap_q;

    logic            hit_scratch;
    logic            hit_mepc;
    logic            hit_mcause;
    logic            hit_mtval;
    logic            wr_act;
    logic [XLEN-1:0] wr_val;

    // Address decode and combinational read of the pre-edge value
    always_comb begin
        hit_scratch = (csr_addr_in == MSCRATCH_ADDR);
        hit_mepc    = (csr_addr_in == MEPC_ADDR);
        hit_mcause  = (csr_addr_in == MCAUSE_ADDR);
        hit_mtval   = (csr_addr_in == MTVAL_ADDR);
        hit_out     = hit_scratch | hit_mepc | hit_mcause | hit_mtval;
        rd_data_out = '0;
        if (hit_scratch)     rd_data_out = mscratch_q;
        else if (hit_mepc)   rd_data_out = mepc_q;
        else if (hit_mcause) rd_data_out = mcause_q;
        else if (hit_mtval)  rd_data_out = mtval_q;
    end

    // Single read-modify-write datapath shared by all four registers
    always_comb begin
        wr_act = wr_en_in && (csr_op_in != 2'b00);
        case (csr_op_in)
            OP_WRITE: wr_val = data_wr_in;
            OP_SET:   wr_val = rd_data_out | data_wr_in;
            OP_CLEAR: wr_val = rd_data_out & ~data_wr_in;
            default:  wr_val = rd_data_out;
        endcase
    end

    // Trap capture overrides CSR writes to mepc/mcause/mtval; mscratch is never trap-owned
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mscratch_q    <= MSCRATCH_RESET;
            mepc_q        <= MEPC_RESET;
            mcause_q      <= '0;
            mtval_q       <= '0;
            in_trap_q     <= 1'b0;
            double_trap_q <= 1'b0;
        end else begin
            if (wr_act && hit_scratch) begin
                mscratch_q <= wr_val;
            end
            if (trap_in) begin
                mepc_q    <= pc_in & EPC_MASK;
                mcause_q  <= cause_in & CAUSE_MASK;
                mtval_q   <= tval_in;
                in_trap_q <= 1'b1;
                if (in_trap_q) begin
                    double_trap_q <= 1'b1;
                end
            end else begin
                if (wr_act && hit_mepc)   mepc_q   <= wr_val & EPC_MASK;
                if (wr_act && hit_mcause) mcause_q <= wr_val & CAUSE_MASK;
                if (wr_act && hit_mtval)  mtval_q  <= wr_val;
                if (mret_in)              in_trap_q <= 1'b0;
            end
        end
    end

    assign mscratch_out    = mscratch_q;
    assign mepc_out        = mepc_q;
    assign mcause_out      = mcause_q;
    assign mtval_out       = mtval_q;
    assign epc_out         = mepc_q;
    assign in_trap_out     = in_trap_q;
    assign double_trap_out = double_trap_q;

endmodule

// File: tb/tb_mtrap_csr_bank.sv
// Vector-table bench for mtrap_csr_bank; a second instance with IALIGN=16 checks the 16-bit mepc mask.
module tb_mtrap_csr_bank;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [11:0] csr_addr_in;
    logic        wr_en_in;
    logic [1:0]  csr_op_in;
    logic [31:0] data_wr_in;
    logic        trap_in;
    logic [31:0] pc_in;
    logic [31:0] cause_in;
    logic [31:0] tval_in;
    logic        mret_in;

    logic [31:0] rd_data_out, mscratch_out, mepc_out, mcause_out, mtval_out, epc_out;
    logic        hit_out, in_trap_out, double_trap_out;
    logic [31:0] rd16, mscratch16, mepc16, mcause16, mtval16, epc16;
    logic        hit16, in_trap16, double_trap16;

    always #5 clk_in = ~clk_in;

    mtrap_csr_bank #(.XLEN(32), .IALIGN(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .csr_addr_in(csr_addr_in),
        .wr_en_in(wr_en_in), .csr_op_in(csr_op_in), .data_wr_in(data_wr_in),
        .trap_in(trap_in), .pc_in(pc_in), .cause_in(cause_in), .tval_in(tval_in),
        .mret_in(mret_in), .rd_data_out(rd_data_out), .hit_out(hit_out),
        .mscratch_out(mscratch_out), .mepc_out(mepc_out), .mcause_out(mcause_out),
        .mtval_out(mtval_out), .epc_out(epc_out), .in_trap_out(in_trap_out),
        .double_trap_out(double_trap_out)
    );

    mtrap_csr_bank #(.XLEN(32), .IALIGN(16)) dut16 (
        .clk_in(clk_in), .rst_in(rst_in), .csr_addr_in(csr_addr_in),
        .wr_en_in(wr_en_in), .csr_op_in(csr_op_in), .data_wr_in(data_wr_in),
        .trap_in(trap_in), .pc_in(pc_in), .cause_in(cause_in), .tval_in(tval_in),
        .mret_in(mret_in), .rd_data_out(rd16), .hit_out(hit16),
        .mscratch_out(mscratch16), .mepc_out(mepc16), .mcause_out(mcause16),
        .mtval_out(mtval16), .epc_out(epc16), .in_trap_out(in_trap16),
        .double_trap_out(double_trap16)
    );

    typedef struct {
        logic        rst;
        logic [11:0] addr;
        logic        wr;
        logic [1:0]  op;
        logic [31:0] data;
        logic        trap;
        logic [31:0] pc;
        logic [31:0] cause;
        logic [31:0] tval;
        logic        mret;
        logic        chk_rd;
        logic [31:0] rd;
        logic        hit;
        logic [31:0] s;
        logic [31:0] e;
        logic [31:0] e16;
        logic [31:0] c;
        logic [31:0] v;
        logic        t;
        logic        d;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] s;
        logic [31:0] e;
        logic [31:0] e16;
        logic [31:0] c;
        logic [31:0] v;
        logic        t;
        logic        d;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_no = 0;

    function automatic vec_t mkv(
        logic rst, logic [11:0] addr, logic wr, logic [1:0] op, logic [31:0] data,
        logic trap, logic [31:0] pc, logic [31:0] cause, logic [31:0] tval, logic mret,
        logic chk_rd, logic [31:0] rd, logic hit,
        logic [31:0] s, logic [31:0] e, logic [31:0] e16, logic [31:0] c, logic [31:0] v,
        logic t, logic d);
        vec_t r;
        r.rst = rst; r.addr = addr; r.wr = wr; r.op = op; r.data = data;
        r.trap = trap; r.pc = pc; r.cause = cause; r.tval = tval; r.mret = mret;
        r.chk_rd = chk_rd; r.rd = rd; r.hit = hit;
        r.s = s; r.e = e; r.e16 = e16; r.c = c; r.v = v; r.t = t; r.d = d;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec%0d %s: got 0x%08h expected 0x%08h", idx, name, act, exp);
        end
    endtask

    // Drive one vector at the falling edge, check the read port, then score the post-edge state
    task automatic run_vec(input vec_t v);
        exp_t x;
        exp_t got;
        @(negedge clk_in);
        rst_in = v.rst; csr_addr_in = v.addr; wr_en_in = v.wr; csr_op_in = v.op;
        data_wr_in = v.data; trap_in = v.trap; pc_in = v.pc; cause_in = v.cause;
        tval_in = v.tval; mret_in = v.mret;
        #1;
        if (v.chk_rd) begin
            chk("rd_data", vec_no, rd_data_out, v.rd);
            chk("hit", vec_no, 32'(hit_out), 32'(v.hit));
        end
        x.idx = vec_no; x.s = v.s; x.e = v.e; x.e16 = v.e16; x.c = v.c; x.v = v.v;
        x.t = v.t; x.d = v.d;
        sb.push_back(x);
        @(posedge clk_in);
        #1;
        got = sb.pop_front();
        chk("mscratch", got.idx, mscratch_out, got.s);
        chk("mepc", got.idx, mepc_out, got.e);
        chk("epc", got.idx, epc_out, got.e);
        chk("mepc_ialign16", got.idx, mepc16, got.e16);
        chk("mcause", got.idx, mcause_out, got.c);
        chk("mtval", got.idx, mtval_out, got.v);
        chk("in_trap", got.idx, 32'(in_trap_out), 32'(got.t));
        chk("double_trap", got.idx, 32'(double_trap_out), 32'(got.d));
        vec_no++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_in = 1'b1; csr_addr_in = 12'h340; wr_en_in = 1'b0; csr_op_in = 2'b00;
        data_wr_in = '0; trap_in = 1'b0; pc_in = '0; cause_in = '0; tval_in = '0;
        mret_in = 1'b0;

        // rst addr wr op data | trap pc cause tval mret | chk rd hit | s e e16 c v t d
        vecs.push_back(mkv(1, 12'h340, 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0,
            32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0));
        vecs.push_back(mkv(0, 12'h340, 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0, 1, 32'h0, 1,
            32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0));
        vecs.push_back(mkv(0, 12'h340, 1, 1, 32'hA5A5_0000, 0, 32'h0, 32'h0, 32'h0, 0, 1, 32'h0, 1,
            32'hA5A5_0000, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0));
        vecs.push_back(mkv(0, 12'h340, 1, 2, 32'h0000_00FF, 0, 32'h0, 32'h0, 32'h0, 0, 1, 32'hA5A5_0000, 1,
            32'hA5A5_00FF, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0));
        vecs.push_back(mkv(0, 12'h340, 1, 3, 32'hA500_0000, 0, 32'h0, 32'h0, 32'h0, 0, 1, 32'hA5A5_00FF, 1,
            32'h00A5_00FF, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0));
        vecs.push_back(mkv(0, 12'h341, 1, 1, 32'h1000_0007, 0, 32'h0, 32'h0, 32'h0, 0, 1, 32'h0, 1,
            32'h00A5_00FF, 32'h1000_0004, 32'h1000_0006, 32'h0, 32'h0, 0, 0));
        vecs.push_back(mkv(0, 12'h340, 1, 0, 32'hFFFF_FFFF, 0, 32'h0, 32'h0, 32'h0, 0, 1, 32'h00A5_00FF, 1,
            32'h00A5_00FF, 32'h1000_0004, 32'h1000_0006, 32'h0, 32'h0, 0, 0));
        vecs.push_back(mkv(0, 12'h344, 1, 1, 32'h1234_5678, 0, 32'h0, 32'h0, 32'h0, 0, 1, 32'h0, 0,
            32'h00A5_00FF, 32'h1000_0004, 32'h1000_0006, 32'h0, 32'h0, 0, 0));
        vecs.push_back(mkv(0, 12'h342, 1, 1, 32'hFFFF_FFFF, 0, 32'h0, 32'h0, 32'h0, 0, 1, 32'h0, 1,
            32'h00A5_00FF, 32'h1000_0004, 32'h1000_0006, 32'h8000_001F, 32'h0, 0, 0));
        vecs.push_back(mkv(0, 12'h343, 1, 1, 32'h0BAD_F00D, 0, 32'h0, 32'h0, 32'h0, 0, 1, 32'h0, 1,
            32'h00A5_00FF, 32'h1000_0004, 32'h1000_0006, 32'h8000_001F, 32'h0BAD_F00D, 0, 0));
        vecs.push_back(mkv(0, 12'h342, 0, 0, 32'h0, 1, 32'h8000_0102, 32'h8000_00FB, 32'hDEAD_BEEF, 0,
            1, 32'h8000_001F, 1,
            32'h00A5_00FF, 32'h8000_0100, 32'h8000_0102, 32'h8000_001B, 32'hDEAD_BEEF, 1, 0));
        vecs.push_back(mkv(0, 12'h341, 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 1, 1, 32'h8000_0100, 1,
            32'h00A5_00FF, 32'h8000_0100, 32'h8000_0102, 32'h8000_001B, 32'hDEAD_BEEF, 0, 0));
        vecs.push_back(mkv(0, 12'h341, 1, 1, 32'h4, 1, 32'h200, 32'h2, 32'h0, 0, 1, 32'h8000_0100, 1,
            32'h00A5_00FF, 32'h200, 32'h200, 32'h2, 32'h0, 1, 0));
        vecs.push_back(mkv(0, 12'h340, 1, 1, 32'h1111_1111, 0, 32'h0, 32'h0, 32'h0, 1, 1, 32'h00A5_00FF, 1,
            32'h1111_1111, 32'h200, 32'h200, 32'h2, 32'h0, 0, 0));
        vecs.push_back(mkv(0, 12'h340, 1, 2, 32'h0000_F000, 1, 32'h304, 32'hB, 32'h55, 0, 1, 32'h1111_1111, 1,
            32'h1111_F111, 32'h304, 32'h304, 32'hB, 32'h55, 1, 0));
        vecs.push_back(mkv(0, 12'h343, 0, 0, 32'h0, 1, 32'h410, 32'h8000_0007, 32'h66, 1, 1, 32'h55, 1,
            32'h1111_F111, 32'h410, 32'h410, 32'h8000_0007, 32'h66, 1, 1));
        vecs.push_back(mkv(0, 12'h343, 1, 1, 32'hFFFF_FFFF, 1, 32'h520, 32'h5, 32'h77, 0, 1, 32'h66, 1,
            32'h1111_F111, 32'h520, 32'h520, 32'h5, 32'h77, 1, 1));
        vecs.push_back(mkv(0, 12'h342, 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 1, 1, 32'h5, 1,
            32'h1111_F111, 32'h520, 32'h520, 32'h5, 32'h77, 0, 1));
        vecs.push_back(mkv(0, 12'h342, 1, 3, 32'h8000_0004, 0, 32'h0, 32'h0, 32'h0, 0, 1, 32'h5, 1,
            32'h1111_F111, 32'h520, 32'h520, 32'h1, 32'h77, 0, 1));
        vecs.push_back(mkv(1, 12'h342, 1, 1, 32'hFFFF_FFFF, 1, 32'h900, 32'h3, 32'h99, 1, 1, 32'h1, 1,
            32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0));
        vecs.push_back(mkv(0, 12'h341, 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0, 1, 32'h0, 1,
            32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i]);
        end

        // Trap state and mepc hold across idle cycles, then a set op cannot defeat the alignment mask
        run_vec(mkv(0, 12'h341, 0, 0, 32'h0, 1, 32'hA03, 32'hFFF, 32'hCAFE, 0, 1, 32'h0, 1,
            32'h0, 32'hA00, 32'hA02, 32'h1F, 32'hCAFE, 1, 0));
        for (int k = 0; k < 3; k++) begin
            run_vec(mkv(0, 12'h341, 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0, 1, 32'hA00, 1,
                32'h0, 32'hA00, 32'hA02, 32'h1F, 32'hCAFE, 1, 0));
        end
        run_vec(mkv(0, 12'h341, 1, 2, 32'h3, 0, 32'h0, 32'h0, 32'h0, 0, 1, 32'hA00, 1,
            32'h0, 32'hA00, 32'hA02, 32'h1F, 32'hCAFE, 1, 0));
        run_vec(mkv(0, 12'h340, 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 1, 1, 32'h0, 1,
            32'h0, 32'hA00, 32'hA02, 32'h1F, 32'hCAFE, 0, 0));

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
